mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_BASE, default 1024: byte address mapped to data-memory word 0.
REQ-002 Parameter ADDR_W, default 16: word-address width on memory side.
REQ-003 Parameter TIMEOUT, default 255: max cycles waiting for mem_ack before abort.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset; sampled only on rising clk.
REQ-006 MEM_R_EN, MEM_W_EN, WB_EN  in  1 each  EXE/MEM controls for the current instruction.
REQ-007 ALU_result  in  32  byte address (loads/stores) or ALU value; ST_value  in  32  store data; Dest  in  5  destination register.
REQ-008 mem_req  out  1  request to data memory; mem_we  out  1  write qualifier; mem_addr  out  ADDR_W  word address; mem_wdata  out  32.
REQ-009 mem_rdata  in  32; mem_ack  in  1  one-cycle completion pulse from memory.
REQ-010 freeze  out  1  stalls PC, IF/ID, ID/EXE and EXE/MEM registers while high.
REQ-011 WB_EN_out, MEM_R_EN_out  out  1; ALU_result_out, MEM_result_out  out  32; Dest_out  out  5  (MEM/WB register).
REQ-012 mem_err  out  1  one-cycle error pulse.

Function
REQ-013 access = MEM_R_EN | MEM_W_EN; when both are high, a write is performed and the read is suppressed (MEM_result_out = 0).
REQ-014 Access is legal iff ALU_result >= DATA_BASE, ALU_result[1:0] == 0, and (ALU_result - DATA_BASE) >> 2 < 2^ADDR_W.
REQ-015 FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-016 IDLE: legal access -> ACCESS at the next edge; the same edge registers mem_req=1, mem_we=MEM_W_EN, mem_addr=(ALU_result-DATA_BASE)>>2, mem_wdata=ST_value; timeout counter cleared.
REQ-017 IDLE: illegal access -> stay IDLE, no mem_req; mem_err pulses 1 cycle; MEM/WB loads with WB_EN_out forced 0.
REQ-018 ACCESS: mem_req, mem_we, mem_addr, mem_wdata held stable until mem_ack or timeout.
REQ-019 ACCESS with mem_ack=1 -> DONE; same edge: mem_req=0, captured read data = mem_rdata (reads) or 0 (writes).
REQ-020 ACCESS with counter == TIMEOUT and no mem_ack -> DONE; mem_req=0, captured data = 0, mem_err pulses, and WB_EN_out is forced 0 for this instruction.
REQ-021 The counter increments each ACCESS cycle without ack; it saturates at TIMEOUT and is 8 bits wide minimum.
REQ-022 DONE -> IDLE unconditionally after 1 cycle; inputs still present in DONE never retrigger an access.
REQ-023 freeze = (IDLE & legal access) | ACCESS; freeze = 0 in DONE and for non-access or illegal instructions.
REQ-024 MEM/WB register loads on every edge with freeze=0; it holds when freeze=1; MEM_result_out = captured data on memory instructions and 0 otherwise.
REQ-025 mem_ack while not in ACCESS is ignored.
REQ-026 Latency: non-memory instruction 1 cycle; legal access with ack k cycles after mem_req rises = k+2 cycles of residence, of which k+1 are frozen.

Reset
REQ-027 rst=0 at an edge: state IDLE, counter 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_err=0, and all MEM/WB outputs 0; this also applies mid-ACCESS, where mem_req drops at that edge.
REQ-028 During rst=0, freeze = 0.

Verification
REQ-029 Load at ALU_result=1032 with mem_ack 3 cycles after mem_req and mem_rdata=0xDEADBEEF -> mem_addr=2, freeze high 4 cycles, then MEM_result_out=0xDEADBEEF, WB_EN_out=1.
REQ-030 Store at ALU_result=1024 with ST_value=0x12345678 and ack after 1 cycle -> mem_we=1, mem_addr=0, mem_wdata=0x12345678, MEM_result_out=0.
REQ-031 Load at ALU_result=1026 (misaligned) or 1020 -> no mem_req, freeze stays 0, mem_err 1-cycle pulse, WB_EN_out=0.
REQ-032 TIMEOUT=4, with mem_ack never asserted -> mem_req drops after 5 ACCESS cycles, mem_err pulses, MEM_result_out=0, WB_EN_out=0.
REQ-033 rst=0 asserted 2 cycles into ACCESS -> next edge mem_req=0, freeze=0, and all outputs 0; a late mem_ack after release is ignored.
REQ-034 Back-to-back load, load, and ALU op, each ack after 1 cycle -> each load frozen 2 cycles, no duplicate requests, and ALU_result_out passes through unchanged for the ALU op.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests, waits for the memory
// handshake (with timeout) and loads the MEM/WB pipeline register.
module mem_stage #(
    parameter int DATA_BASE = 1024,
    parameter int ADDR_W    = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic              WB_EN,
    input  logic [31:0]       ALU_result,
    input  logic [31:0]       ST_value,
    input  logic [4:0]        Dest,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              freeze,
    output logic              WB_EN_out,
    output logic              MEM_R_EN_out,
    output logic [31:0]       ALU_result_out,
    output logic [31:0]       MEM_result_out,
    output logic [4:0]        Dest_out,
    output logic              mem_err
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [31:0] BASE = 32'(DATA_BASE);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [31:0]      cap_data;
    logic             timed_out;

    logic             access;
    logic             legal;
    logic [31:0]      offset;
    logic [29:0]      word;

    assign access = MEM_R_EN | MEM_W_EN;
    assign offset = ALU_result - BASE;
    assign word   = 30'(offset >> 2);
    assign legal  = (ALU_result >= BASE) && (ALU_result[1:0] == 2'b00)
                    && ((word >> ADDR_W) == 30'd0);

    // Upstream must hold its instruction while the request is being set up or is outstanding.
    assign freeze = rst && (((state == IDLE) && access && legal) || (state == ACCESS));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            count          <= '0;
            cap_data       <= '0;
            timed_out      <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_err        <= 1'b0;
            WB_EN_out      <= 1'b0;
            MEM_R_EN_out   <= 1'b0;
            ALU_result_out <= '0;
            MEM_result_out <= '0;
            Dest_out       <= '0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && legal) begin
                        state     <= ACCESS;
                        mem_req   <= 1'b1;
                        mem_we    <= MEM_W_EN;
                        mem_addr  <= ADDR_W'(word);
                        mem_wdata <= ST_value;
                        count     <= '0;
                        timed_out <= 1'b0;
                    end else begin
                        // Non-memory op passes through; a bad address kills the write-back.
                        mem_err        <= access;
                        WB_EN_out      <= WB_EN & ~access;
                        MEM_R_EN_out   <= MEM_R_EN;
                        ALU_result_out <= ALU_result;
                        MEM_result_out <= '0;
                        Dest_out       <= Dest;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        cap_data <= mem_we ? 32'd0 : mem_rdata;
                    end else if (count == CNT_MAX) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        cap_data  <= '0;
                        timed_out <= 1'b1;
                        mem_err   <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    WB_EN_out      <= WB_EN & ~timed_out;
                    MEM_R_EN_out   <= MEM_R_EN;
                    ALU_result_out <= ALU_result;
                    MEM_result_out <= cap_data;
                    Dest_out       <= Dest;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: an instruction-level model predicts every
// cycle's outputs from latency rules and a negedge process compares them.
module tb_mem_stage;

    localparam int DATA_BASE = 1024;
    localparam int ADDR_W    = 16;
    localparam int TIMEOUT   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              MEM_R_EN, MEM_W_EN, WB_EN;
    logic [31:0]       ALU_result, ST_value;
    logic [4:0]        Dest;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              mem_ack;
    logic              freeze;
    logic              WB_EN_out, MEM_R_EN_out;
    logic [31:0]       ALU_result_out, MEM_result_out;
    logic [4:0]        Dest_out;
    logic              mem_err;

    mem_stage #(.DATA_BASE(DATA_BASE), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
        .ALU_result(ALU_result), .ST_value(ST_value), .Dest(Dest),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze),
        .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
        .ALU_result_out(ALU_result_out), .MEM_result_out(MEM_result_out),
        .Dest_out(Dest_out), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              fz, rq, we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        bit                regs;
        logic              err, wb, rd;
        logic [31:0]       alu, res;
        logic [4:0]        dest;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    // Model of the MEM/WB register and the pending error pulse.
    logic        m_wb, m_rd, m_err;
    logic [31:0] m_alu, m_res;
    logic [4:0]  m_dest;

    // Observation counters used by the literal checks.
    int                freeze_cnt, req_cnt, req_rises;
    logic              prev_req;
    logic [ADDR_W-1:0] last_addr;
    logic              last_we;
    logic [31:0]       last_wdata;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic fz, input logic rq, input logic we,
                        input logic [ADDR_W-1:0] ad, input logic [31:0] wd, input bit regs);
        exp_t e;
        e.fz = fz; e.rq = rq; e.we = we; e.addr = ad; e.wdata = wd; e.regs = regs;
        e.err = m_err; e.wb = m_wb; e.rd = m_rd; e.alu = m_alu; e.res = m_res; e.dest = m_dest;
        expq.push_back(e);
    endtask

    task automatic model_clear();
        m_wb = 0; m_rd = 0; m_err = 0; m_alu = 0; m_res = 0; m_dest = 0;
    endtask

    // k = cycle of mem_req on which ack arrives (1 = first), 0 = never.
    task automatic applyStimulus(input logic r, input logic w, input logic wb,
                                 input logic [31:0] alu, input logic [31:0] st,
                                 input logic [4:0] dst, input int k, input logic [31:0] rdata);
        longint            off;
        bit                acc, legal;
        logic [ADDR_W-1:0] wa;
        int                n;
        acc   = r | w;
        off   = longint'({32'd0, alu}) - longint'(DATA_BASE);
        legal = (off >= 0) && (alu[1:0] == 2'b00) && ((off >> 2) < (longint'(1) << ADDR_W));
        wa    = ADDR_W'(off >> 2);
        MEM_R_EN = r; MEM_W_EN = w; WB_EN = wb; ALU_result = alu; ST_value = st; Dest = dst;
        mem_ack = 0; mem_rdata = 32'h0BAD0BAD;
        if (!acc || !legal) begin
            push(0, 0, 0, '0, '0, 1);
            tick();
            m_wb = wb & ~acc; m_rd = r; m_alu = alu; m_res = 0; m_dest = dst; m_err = acc;
        end else begin
            n = (k > 0) ? k : TIMEOUT + 1;
            push(1, 0, 0, '0, '0, 1);
            tick();
            m_err = 0;
            for (int i = 1; i <= n; i++) begin
                mem_ack   = (i == k);
                mem_rdata = (i == k) ? rdata : 32'h0BAD0BAD;
                push(1, 1, w, wa, st, 1);
                tick();
            end
            // A stray ack here must be ignored.
            mem_ack = 1; mem_rdata = 32'h55AA55AA;
            m_err = (k == 0);
            push(0, 0, 0, '0, '0, 1);
            tick();
            mem_ack = 0;
            m_wb = wb && (k > 0); m_rd = r; m_alu = alu; m_dest = dst; m_err = 0;
            m_res = (k > 0 && !w) ? rdata : 32'd0;
        end
    endtask

    task automatic clear_counts();
        freeze_cnt = 0; req_cnt = 0; req_rises = 0;
    endtask

    always @(negedge clk) begin
        if (freeze === 1'b1) freeze_cnt++;
        if (mem_req === 1'b1) begin
            req_cnt++;
            last_addr = mem_addr; last_we = mem_we; last_wdata = mem_wdata;
            if (prev_req !== 1'b1) req_rises++;
        end
        prev_req = mem_req;
    end

    always @(negedge clk) begin
        exp_t c;
        if (expq.size() > 0) begin
            c = expq.pop_front();
            checkOutput("freeze", {31'd0, freeze}, {31'd0, c.fz});
            checkOutput("mem_req", {31'd0, mem_req}, {31'd0, c.rq});
            if (c.rq) begin
                checkOutput("mem_we", {31'd0, mem_we}, {31'd0, c.we});
                checkOutput("mem_addr", 32'(mem_addr), 32'(c.addr));
                checkOutput("mem_wdata", mem_wdata, c.wdata);
            end
            if (c.regs) begin
                checkOutput("mem_err", {31'd0, mem_err}, {31'd0, c.err});
                checkOutput("WB_EN_out", {31'd0, WB_EN_out}, {31'd0, c.wb});
                checkOutput("MEM_R_EN_out", {31'd0, MEM_R_EN_out}, {31'd0, c.rd});
                checkOutput("ALU_result_out", ALU_result_out, c.alu);
                checkOutput("MEM_result_out", MEM_result_out, c.res);
                checkOutput("Dest_out", {27'd0, Dest_out}, {27'd0, c.dest});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 0; MEM_R_EN = 0; MEM_W_EN = 0; WB_EN = 0; ALU_result = 0; ST_value = 0; Dest = 0;
        mem_ack = 0; mem_rdata = 0; prev_req = 0;
        clear_counts();
        tick();
        model_clear();
        push(0, 0, 0, '0, '0, 1);
        tick();
        rst = 1;

        // Plain ALU op
        applyStimulus(0, 0, 1, 32'h00001234, 32'h0, 5'd3, 0, 32'h0);
        checkOutput("alu_pass", ALU_result_out, 32'h00001234);

        // Load 1032, ack on third request cycle
        clear_counts();
        applyStimulus(1, 0, 1, 32'd1032, 32'h0, 5'd7, 3, 32'hDEADBEEF);
        checkOutput("load_addr", 32'(last_addr), 32'd2);
        checkOutput("load_freeze_cycles", freeze_cnt, 4);
        checkOutput("load_result", MEM_result_out, 32'hDEADBEEF);
        checkOutput("load_wb", {31'd0, WB_EN_out}, 32'd1);

        // Store 1024, ack on first request cycle
        applyStimulus(0, 1, 0, 32'd1024, 32'h12345678, 5'd0, 1, 32'hCAFEF00D);
        checkOutput("store_we", {31'd0, last_we}, 32'd1);
        checkOutput("store_addr", 32'(last_addr), 32'd0);
        checkOutput("store_wdata", last_wdata, 32'h12345678);
        checkOutput("store_result", MEM_result_out, 32'd0);

        // Misaligned and below-base loads
        clear_counts();
        applyStimulus(1, 0, 1, 32'd1026, 32'h0, 5'd4, 1, 32'h0);
        checkOutput("misalign_err", {31'd0, mem_err}, 32'd1);
        checkOutput("misalign_wb", {31'd0, WB_EN_out}, 32'd0);
        applyStimulus(1, 0, 1, 32'd1020, 32'h0, 5'd4, 1, 32'h0);
        checkOutput("below_err", {31'd0, mem_err}, 32'd1);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        checkOutput("illegal_no_req", req_cnt, 0);
        checkOutput("illegal_no_freeze", freeze_cnt, 0);

        // Both enables: write wins, read data suppressed
        applyStimulus(1, 1, 1, 32'd1040, 32'hA5A5A5A5, 5'd9, 2, 32'h11112222);
        checkOutput("both_result", MEM_result_out, 32'd0);

        // Top of the address window and one word past it
        applyStimulus(1, 0, 1, 32'd263164, 32'h0, 5'd10, 2, 32'h0F0F0F0F);
        checkOutput("top_addr", 32'(last_addr), 32'h0000FFFF);
        applyStimulus(1, 0, 1, 32'd263168, 32'h0, 5'd11, 1, 32'h0);
        checkOutput("past_top_err", {31'd0, mem_err}, 32'd1);

        // Timeout: ack never comes
        clear_counts();
        applyStimulus(1, 0, 1, 32'd1048, 32'h0, 5'd12, 0, 32'h0);
        checkOutput("timeout_req_cycles", req_cnt, 5);
        checkOutput("timeout_result", MEM_result_out, 32'd0);
        checkOutput("timeout_wb", {31'd0, WB_EN_out}, 32'd0);

        // Back-to-back load, load, ALU op
        clear_counts();
        applyStimulus(1, 0, 1, 32'd1028, 32'h0, 5'd1, 1, 32'h00000111);
        applyStimulus(1, 0, 1, 32'd1032, 32'h0, 5'd2, 1, 32'h00000222);
        applyStimulus(0, 0, 1, 32'h00ABCDEF, 32'h0, 5'd3, 0, 32'h0);
        checkOutput("b2b_rises", req_rises, 2);
        checkOutput("b2b_freeze_cycles", freeze_cnt, 4);
        checkOutput("b2b_alu", ALU_result_out, 32'h00ABCDEF);

        // Reset two cycles into ACCESS, then a late ack
        MEM_R_EN = 1; MEM_W_EN = 0; WB_EN = 1; ALU_result = 32'd1036; ST_value = 32'h0; Dest = 5'd6;
        mem_ack = 0;
        push(1, 0, 0, '0, '0, 1);
        tick();
        m_err = 0;
        push(1, 1, 0, 16'd3, 32'h0, 1);
        tick();
        push(1, 1, 0, 16'd3, 32'h0, 1);
        tick();
        rst = 0;
        push(0, 1, 0, 16'd3, 32'h0, 1);
        tick();
        model_clear();
        rst = 1; MEM_R_EN = 0; WB_EN = 0; ALU_result = 32'h77; Dest = 5'd0; mem_ack = 1;
        checkOutput("rst_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_wb", {31'd0, WB_EN_out}, 32'd0);
        checkOutput("rst_alu", ALU_result_out, 32'd0);
        push(0, 0, 0, '0, '0, 1);
        tick();
        mem_ack = 0;
        m_alu = 32'h77;
        applyStimulus(0, 0, 1, 32'h00000042, 32'h0, 5'd8, 0, 32'h0);
        checkOutput("post_rst_no_req", {31'd0, mem_req}, 32'd0);

        for (int i = 0; i < 20 && expq.size() > 0; i++) tick();
        if (expq.size() > 0) checkOutput("queue_drain", expq.size(), 0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
